// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface fetch_unit_if #(
  parameter int unsigned WORD_SIZE = 16
) ();
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;

  modport master (output i_readM, output i_address, input  i_data, input  i_ready);
  modport slave  (input  i_readM, input  i_address, output i_data, output i_ready);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues instruction-memory reads and loads IF/ID.
module fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_unit_if.master         imem,
  input  logic [WORD_SIZE-1:0] predicted_pc,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 stall,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_instr,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] next_q, next_d;
  logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_SIZE-1:0] hold_pc_q, hold_pc_d;
  logic [WORD_SIZE-1:0] hold_pred_q, hold_pred_d;
  logic                 ifv_q, ifv_d;
  logic [WORD_SIZE-1:0] ifi_q, ifi_d;
  logic [WORD_SIZE-1:0] ifp_q, ifp_d;
  logic [WORD_SIZE-1:0] ifpr_q, ifpr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= RESET_PC;
      next_q       <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_pred_q  <= '0;
      ifv_q        <= 1'b0;
      ifi_q        <= '0;
      ifp_q        <= '0;
      ifpr_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      next_q       <= next_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_pred_q  <= hold_pred_d;
      ifv_q        <= ifv_d;
      ifi_q        <= ifi_d;
      ifp_q        <= ifp_d;
      ifpr_q       <= ifpr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH: begin
        if (redirect)                     state_d = imem.i_ready ? FETCH : DISCARD;
        else if (imem.i_ready && stall)   state_d = HOLD;
      end
      HOLD:    if (redirect || !stall) state_d = FETCH;
      DISCARD: if (imem.i_ready)       state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    next_d       = next_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_pred_d  = hold_pred_q;
    ifv_d        = stall ? ifv_q : 1'b0;
    ifi_d        = ifi_q;
    ifp_d        = ifp_q;
    ifpr_d       = ifpr_q;
    case (state_q)
      // A redirect seen while idle goes straight to the first request address.
      IDLE: addr_d = redirect ? redirect_pc : next_q;
      FETCH: begin
        if (imem.i_ready) begin
          if (redirect) begin
            addr_d = redirect_pc;
          end else if (!stall) begin
            ifv_d  = 1'b1;
            ifi_d  = imem.i_data;
            ifp_d  = addr_q;
            ifpr_d = predicted_pc;
            addr_d = predicted_pc;
          end else begin
            hold_instr_d = imem.i_data;
            hold_pc_d    = addr_q;
            hold_pred_d  = predicted_pc;
            next_d       = predicted_pc;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          addr_d = redirect_pc;
        end else if (!stall) begin
          ifv_d  = 1'b1;
          ifi_d  = hold_instr_q;
          ifp_d  = hold_pc_q;
          ifpr_d = hold_pred_q;
          addr_d = next_q;
        end
      end
      DISCARD: if (imem.i_ready) addr_d = redirect ? redirect_pc : next_q;
      default: ;
    endcase
    if (redirect) begin
      next_d       = redirect_pc;
      ifv_d        = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      hold_pred_d  = '0;
    end
  end

  always_comb begin
    imem.i_readM   = (state_q == FETCH) || (state_q == DISCARD);
    imem.i_address = addr_q;
    pc             = addr_q;
    if_valid       = ifv_q;
    if_instr       = ifi_q;
    if_pc          = ifp_q;
    if_pred_pc     = ifpr_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID words plus point checks.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] predicted_pc, redirect_pc, pc;
  logic        redirect, stall;
  logic        if_valid;
  logic [15:0] if_instr, if_pc, if_pred_pc;
  int          checks = 0;
  int          errors = 0;
  int unsigned lat = 0;
  int unsigned cnt = 0;

  typedef struct packed { logic [15:0] instr, pc, pred; } exp_t;
  exp_t sb[$];

  fetch_unit_if #(.WORD_SIZE(16)) mif ();

  fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .imem(mif),
    .predicted_pc(predicted_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .pc(pc), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pred_pc(if_pred_pc)
  );

  always #5 clk = ~clk;

  // Predictor and memory models: pc+1 prediction, word = {4'hA, addr[11:0]}, 'lat' wait cycles.
  assign predicted_pc = pc + 16'd1;
  assign mif.i_ready  = mif.i_readM && (cnt >= lat);
  assign mif.i_data   = mif.i_ready ? {4'hA, mif.i_address[11:0]} : 16'h0000;

  always @(posedge clk) begin
    if (!mif.i_readM || mif.i_ready) cnt <= 0;
    else                             cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] pred);
    sb.push_back({instr, a, pred});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: a live IF/ID after an unstalled edge is a freshly loaded word.
  always @(posedge clk) begin
    logic stall_s;
    exp_t e;
    stall_s = stall;
    #1;
    if (reset_n && if_valid && !stall_s) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word pc=%h with empty scoreboard", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", if_instr, e.instr);
        chk("sb_pc", if_pc, e.pc);
        chk("sb_pred", if_pred_pc, e.pred);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    step();
    chk("rst_readM", {15'd0, mif.i_readM}, 16'd0);
    chk("rst_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_addr", mif.i_address, 16'h0000);
    chk("rst_if_pc", if_pc, 16'h0000);
    reset_n = 1'b1;
    push(16'hA000, 16'h0000, 16'h0001);
    push(16'hA001, 16'h0001, 16'h0002);
    push(16'hA002, 16'h0002, 16'h0003);
    push(16'hA003, 16'h0003, 16'h0004);
    push(16'hA004, 16'h0004, 16'h0005);
    #1 chk("idle_readM", {15'd0, mif.i_readM}, 16'd0);
    step();
    chk("first_readM", {15'd0, mif.i_readM}, 16'd1);
    chk("first_addr", mif.i_address, 16'h0000);
    step();
    step();
    stall = 1'b1;
    step();
    chk("hold_readM", {15'd0, mif.i_readM}, 16'd0);
    chk("hold_if_pc", if_pc, 16'h0001);
    chk("hold_valid", {15'd0, if_valid}, 16'd1);
    step();
    chk("hold2_readM", {15'd0, mif.i_readM}, 16'd0);
    stall = 1'b0;
    step();
    chk("unstall_readM", {15'd0, mif.i_readM}, 16'd1);
    chk("unstall_addr", mif.i_address, 16'h0003);
    chk("unstall_if_pc", if_pc, 16'h0002);
    step();
    step();
    chk("pre_redir_addr", mif.i_address, 16'h0005);
    lat = 3; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("disc_addr0", mif.i_address, 16'h0005);
    chk("disc_readM", {15'd0, mif.i_readM}, 16'd1);
    chk("disc_valid", {15'd0, if_valid}, 16'd0);
    step();
    chk("disc_addr1", mif.i_address, 16'h0005);
    step();
    chk("disc_addr2", mif.i_address, 16'h0005);
    step();
    chk("after_disc_addr", mif.i_address, 16'h0040);
    chk("after_disc_valid", {15'd0, if_valid}, 16'd0);
    lat = 0;
    push(16'hA040, 16'h0040, 16'h0041);
    step();
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    chk("rdy_redir_addr", mif.i_address, 16'h0100);
    chk("rdy_redir_valid", {15'd0, if_valid}, 16'd0);
    chk("rdy_redir_readM", {15'd0, mif.i_readM}, 16'd1);
    push(16'hA100, 16'h0100, 16'h0101);
    step();
    stall = 1'b1;
    step();
    chk("h_redir_readM", {15'd0, mif.i_readM}, 16'd0);
    chk("h_redir_valid0", {15'd0, if_valid}, 16'd1);
    chk("h_redir_if_pc", if_pc, 16'h0100);
    redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("h_redir_valid", {15'd0, if_valid}, 16'd0);
    chk("h_redir_addr", mif.i_address, 16'h0200);
    chk("h_redir_readM1", {15'd0, mif.i_readM}, 16'd1);
    push(16'hA200, 16'h0200, 16'h0201);
    step();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("wrap_addr", mif.i_address, 16'hFFFF);
    chk("wrap_valid", {15'd0, if_valid}, 16'd0);
    push(16'hAFFF, 16'hFFFF, 16'h0000);
    push(16'hA000, 16'h0000, 16'h0001);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("async_rst_readM", {15'd0, mif.i_readM}, 16'd0);
    chk("async_rst_valid", {15'd0, if_valid}, 16'd0);
    chk("async_rst_addr", mif.i_address, 16'h0000);
    step();
    reset_n = 1'b1;
    #1 chk("re_idle_readM", {15'd0, mif.i_readM}, 16'd0);
    push(16'hA000, 16'h0000, 16'h0001);
    step();
    chk("re_first_readM", {15'd0, mif.i_readM}, 16'd1);
    chk("re_first_addr", mif.i_address, 16'h0000);
    step();
    stall = 1'b1;
    step();
    chk("end_hold_readM", {15'd0, mif.i_readM}, 16'd0);
    step();
    step();
    chk("sb_empty", sb.size()[15:0], 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
